usr_seq_ctrl: RTL and testbench
===============================

USR_SEQ_CTRL -- requirements
Module: usr_seq_ctrl

Interface
REQ-001 SHALL have the port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have the port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have the port `cmd_valid`, input, 1 bit: a command is offered.
REQ-004 SHALL have the port `cmd_ready`, output, 1 bit: the controller accepts a command this cycle.
REQ-005 SHALL have the port `cmd_op`, input, 3 bits: 000 LOAD, 001 SHR (shift right), 010 SHL (shift left), 011 ROR (rotate right), 100 ROL (rotate left); 101-111 reserved.
REQ-006 SHALL have the port `cmd_data`, input, 4 bits: parallel value for LOAD.
REQ-007 SHALL have the port `cmd_cnt`, input, 3 bits: step count for shifts and rotates, 0..7.
REQ-008 SHALL have the port `cmd_si`, input, 1 bit: fill bit for SHR/SHL.
REQ-009 SHALL have the port `abort`, input, 1 bit: cancel the command in progress.
REQ-010 SHALL have the port `usr_q`, input, 4 bits: present contents of the shift register.
REQ-011 SHALL have the port `usr_mode`, output, 2 bits: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-012 SHALL have the port `usr_par_in`, output, 4 bits: parallel data to the shift register.
REQ-013 SHALL have the port `usr_si`, output, 1 bit: serial input to the shift register.
REQ-014 SHALL have the port `busy`, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-015 SHALL have the port `done`, output, 1 bit: one-cycle completion pulse.
REQ-016 SHALL have the port `res`, output, 4 bits: equals `usr_q` while `done`=1, 0 otherwise.

Function
REQ-017 SHALL implement the FSM states IDLE, LOAD, SHIFT and DONE.
REQ-018 SHALL drive `cmd_ready`=1 only in IDLE; a command is accepted on the edge where `cmd_valid`&`cmd_ready` are both 1.
REQ-019 SHALL transition on acceptance as follows: LOAD op -> LOAD state; shift/rotate op with `cmd_cnt`>0 -> SHIFT; `cmd_cnt`=0 -> DONE directly.
REQ-020 SHALL treat a reserved op as accepted, with no register activity, and go straight to DONE.
REQ-021 SHALL hold LOAD for exactly 1 cycle with `usr_mode`=11 and `usr_par_in`=latched `cmd_data`, then go to DONE.
REQ-022 SHALL remain in SHIFT for exactly N=`cmd_cnt` cycles, with a 3-bit down-counter loaded with N on acceptance and decremented each SHIFT cycle; the state exits to DONE when the count is 1.
REQ-023 SHALL drive `usr_mode`=01 for SHR/ROR and 10 for SHL/ROL in every SHIFT cycle.
REQ-024 SHALL drive `usr_si` in SHIFT as: SHR/SHL use latched `cmd_si`; ROR uses `usr_q[0]`; ROL uses `usr_q[3]` (combinational from the current `usr_q`).
REQ-025 SHALL assume the following shift register convention: shift right enters SI at bit 3 and drops bit 0; shift left enters SI at bit 0 and drops bit 3.
REQ-026 SHALL hold DONE for exactly 1 cycle with `done`=1 and `usr_mode`=00, then return to IDLE.
REQ-027 SHALL produce `done` with latency from the acceptance edge t as follows: LOAD at t+2; shift/rotate N>0 at t+N+1; N=0 or reserved op at t+1.
REQ-028 SHALL drive `usr_mode`=00, `usr_par_in`=0 and `usr_si`=0 in IDLE and DONE.
REQ-029 SHALL, when `abort`=1 in LOAD or SHIFT, go to IDLE on that edge: no `done`, `usr_mode`=00 from the next cycle, and the shifts already applied stand.
REQ-030 SHALL ignore `abort` in IDLE and DONE.
REQ-031 SHALL capture command fields only on acceptance; input changes while `busy`=1 have no effect.
REQ-032 SHALL NOT accept back-to-back commands without at least one IDLE cycle between them, since DONE always precedes IDLE.

Reset
REQ-033 SHALL, when `rst`=1 at an edge, force IDLE, counter=0, and all latched fields=0.
REQ-034 SHALL drive, in the cycle after reset, `usr_mode`=00, `usr_par_in`=0, `usr_si`=0, `busy`=0, `done`=0, `res`=0 and `cmd_ready`=1.
REQ-035 SHALL give `rst` priority over `abort` and over command acceptance.
REQ-036 SHALL, on reset mid-operation, drop the command silently with no `done`.
REQ-037 SHALL NOT reset the shift register itself; that has a separate reset.

Structure
REQ-038 SHALL take the op codes, the `usr_mode` codes and the state encoding from the shared package usr_ctrl_pkg.
REQ-039 SHALL be a single module with no sub-modules; the step counter and FSM stay inline.
REQ-040 SHALL register the FSM state, counter and latched fields, with outputs decoded combinationally from the state.

Verification
REQ-041 SHALL cover LOAD `cmd_data`=1010 accepted at t -> `usr_mode`=11, `usr_par_in`=1010 at t+1; `done`=1, `res`=1010 at t+2.
REQ-042 SHALL cover `usr_q`=1010, SHR N=2, si=1 -> `usr_mode`=01 at t+1 and t+2; `done` at t+3, `res`=1110.
REQ-043 SHALL cover `usr_q`=1001, ROL N=4 -> `usr_si` follows `usr_q[3]` each step; `done` at t+5, `res`=1001.
REQ-044 SHALL cover SHL N=0 -> `usr_mode` never leaves 00; `done` at t+1, `res`=`usr_q` unchanged.
REQ-045 SHALL cover SHR N=7, `abort` in the 3rd SHIFT cycle -> `usr_mode`=00 next cycle, `done` never asserts, `cmd_ready`=1; a new command held on `cmd_valid` throughout the busy period is accepted only then.
REQ-046 SHALL cover `rst` asserted during SHIFT of ROR N=5 -> next cycle IDLE with all outputs at reset values and no `done`.

Source files
------------

// File: rtl/usr_ctrl_pkg.sv
// Shared encodings for the universal-shift-register sequencing controller:
// command op codes, register mode codes and FSM state encoding.
package usr_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_SHR  = 3'b001,
        OP_SHL  = 3'b010,
        OP_ROR  = 3'b011,
        OP_ROL  = 3'b100
    } op_t;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Ops that step the register one position per SHIFT cycle.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) || (op == OP_ROL);
    endfunction

endpackage

// File: rtl/usr_seq_ctrl.sv
// Sequencing controller for an external 4-bit universal shift register:
// accepts LOAD/shift/rotate commands and steps the register N times.
module usr_seq_ctrl
    import usr_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_data,
    input  logic [2:0] cmd_cnt,
    input  logic       cmd_si,
    input  logic       abort,
    input  logic [3:0] usr_q,
    output logic [1:0] usr_mode,
    output logic [3:0] usr_par_in,
    output logic       usr_si,
    output logic       busy,
    output logic       done,
    output logic [3:0] res
);

    state_t     state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;
    logic [2:0] op_reg, op_next;
    logic [3:0] data_reg, data_next;
    logic       si_reg, si_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 3'd0;
            op_reg    <= 3'd0;
            data_reg  <= 4'd0;
            si_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            data_reg  <= data_next;
            si_reg    <= si_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        data_next  = data_reg;
        si_next    = si_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_next   = cmd_op;
                    data_next = cmd_data;
                    si_next   = cmd_si;
                    cnt_next  = cmd_cnt;
                    // Reserved ops and zero-length shifts complete with no register activity.
                    if (cmd_op == OP_LOAD)
                        state_next = ST_LOAD;
                    else if (is_shift_op(cmd_op) && (cmd_cnt != 3'd0))
                        state_next = ST_SHIFT;
                    else
                        state_next = ST_DONE;
                end
            end
            ST_LOAD: begin
                state_next = abort ? ST_IDLE : ST_DONE;
            end
            ST_SHIFT: begin
                cnt_next = cnt_reg - 3'd1;
                if (abort)
                    state_next = ST_IDLE;
                else if (cnt_reg == 3'd1)
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        usr_mode   = MODE_HOLD;
        usr_par_in = 4'd0;
        usr_si     = 1'b0;
        cmd_ready  = (state_reg == ST_IDLE);
        busy       = (state_reg != ST_IDLE);
        done       = (state_reg == ST_DONE);
        res        = 4'd0;
        case (state_reg)
            ST_LOAD: begin
                usr_mode   = MODE_LOAD;
                usr_par_in = data_reg;
            end
            ST_SHIFT: begin
                usr_mode = ((op_reg == OP_SHR) || (op_reg == OP_ROR)) ? MODE_SHR : MODE_SHL;
                // Rotates feed back the bit about to fall off the far end.
                case (op_reg)
                    OP_ROR:  usr_si = usr_q[0];
                    OP_ROL:  usr_si = usr_q[3];
                    default: usr_si = si_reg;
                endcase
            end
            ST_DONE: begin
                res = usr_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Bench for usr_seq_ctrl: models the attached shift register and checks
// each command against an arithmetic reference of the expected result.
module tb_usr_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [3:0] cmd_data = 4'd0;
    logic [2:0] cmd_cnt = 3'd0;
    logic       cmd_si = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] usr_q;
    logic [1:0] usr_mode;
    logic [3:0] usr_par_in;
    logic       usr_si;
    logic       busy;
    logic       done;
    logic [3:0] res;

    logic [3:0] sr = 4'd0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    usr_seq_ctrl dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt), .cmd_si(cmd_si),
        .abort(abort), .usr_q(usr_q), .usr_mode(usr_mode), .usr_par_in(usr_par_in),
        .usr_si(usr_si), .busy(busy), .done(done), .res(res)
    );

    // External shift register: right enters SI at bit 3, left enters SI at bit 0.
    assign usr_q = sr;
    always @(posedge clk) begin
        case (usr_mode)
            2'b01: sr <= {usr_si, sr[3:1]};
            2'b10: sr <= {sr[2:0], usr_si};
            2'b11: sr <= usr_par_in;
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Register value after n steps of op, computed with integer arithmetic.
    function automatic logic [3:0] ref_result(input logic [2:0] op, input logic [3:0] q,
                                              input logic [3:0] d, input int n, input logic si);
        int v;
        v = int'(q);
        if (op == 3'd0) return d;
        for (int k = 0; k < n; k++) begin
            case (op)
                3'd1: v = (v / 2) + (si ? 8 : 0);
                3'd2: v = ((v * 2) % 16) + (si ? 1 : 0);
                3'd3: v = (v / 2) + ((v % 2) * 8);
                3'd4: v = ((v * 2) % 16) + (v / 8);
                default: ;
            endcase
        end
        return v[3:0];
    endfunction

    task automatic do_cmd(input logic [2:0] op, input logic [3:0] d, input logic [2:0] n,
                          input logic s);
        int dc;
        int exp_mode;
        logic [3:0] q0, exp_q;
        logic exp_si;
        bit is_sh;
        is_sh = (op >= 3'd1) && (op <= 3'd4);
        dc = (op == 3'd0) ? 2 : ((is_sh && n != 0) ? int'(n) + 1 : 1);
        exp_mode = (op == 3'd0) ? 3 : ((op == 3'd1 || op == 3'd3) ? 1 : 2);
        @(posedge clk); #1;
        q0 = sr;
        exp_q = is_sh ? ref_result(op, q0, d, int'(n), s) : ((op == 3'd0) ? d : q0);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_cnt = n; cmd_si = s;
        abort = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("ready_idle", {7'd0, cmd_ready}, 8'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; abort = 1'b0;
        cmd_op = 3'($urandom); cmd_data = 4'($urandom); cmd_cnt = 3'($urandom);
        cmd_si = 1'($urandom);
        for (int c = 1; c <= dc; c++) begin
            @(negedge clk);
            if (c < dc) begin
                chk("mode_busy", {6'd0, usr_mode}, 8'(exp_mode));
                chk("busy", {7'd0, busy}, 8'd1);
                chk("done_early", {7'd0, done}, 8'd0);
                chk("res_zero", {4'd0, res}, 8'd0);
                if (op == 3'd0) chk("par_in", {4'd0, usr_par_in}, {4'd0, d});
                else begin
                    exp_si = (op == 3'd3) ? sr[0] : ((op == 3'd4) ? sr[3] : s);
                    chk("shift_si", {7'd0, usr_si}, {7'd0, exp_si});
                end
            end else begin
                chk("done", {7'd0, done}, 8'd1);
                chk("mode_done", {6'd0, usr_mode}, 8'd0);
                chk("res", {4'd0, res}, {4'd0, exp_q});
                chk("si_done", {7'd0, usr_si}, 8'd0);
            end
        end
        @(negedge clk);
        chk("done_pulse", {7'd0, done}, 8'd0);
        chk("ready_back", {7'd0, cmd_ready}, 8'd1);
        $display("[TB] op=%0d data=%h cnt=%0d si=%0d q0=%h -> res=%h", op, d, n, s, q0, exp_q);
    endtask

    initial begin
        // Reset wins over a simultaneously offered command and abort.
        cmd_valid = 1'b1; abort = 1'b1; cmd_op = 3'd1; cmd_cnt = 3'd3;
        repeat (2) @(posedge clk);
        #1;
        cmd_valid = 1'b0; abort = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("rst_mode", {6'd0, usr_mode}, 8'd0);
        chk("rst_par", {4'd0, usr_par_in}, 8'd0);
        chk("rst_si", {7'd0, usr_si}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_res", {4'd0, res}, 8'd0);
        chk("rst_ready", {7'd0, cmd_ready}, 8'd1);

        do_cmd(3'd0, 4'b1010, 3'd0, 1'b0);
        chk("load_1010", {4'd0, sr}, 8'b1010);
        do_cmd(3'd1, 4'd0, 3'd2, 1'b1);
        chk("shr2_1110", {4'd0, sr}, 8'b1110);
        do_cmd(3'd0, 4'b1001, 3'd0, 1'b0);
        do_cmd(3'd4, 4'd0, 3'd4, 1'b0);
        chk("rol4_1001", {4'd0, sr}, 8'b1001);
        do_cmd(3'd2, 4'd0, 3'd0, 1'b1);
        chk("shl0_same", {4'd0, sr}, 8'b1001);
        do_cmd(3'd6, 4'hF, 3'd5, 1'b1);
        chk("reserved_same", {4'd0, sr}, 8'b1001);

        // Abort in the 3rd SHIFT cycle of SHR 7 while a LOAD waits on cmd_valid.
        do_cmd(3'd0, 4'b1111, 3'd0, 1'b0);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_cnt = 3'd7; cmd_si = 1'b0;
        @(negedge clk);
        chk("ab_ready", {7'd0, cmd_ready}, 8'd1);
        @(posedge clk); #1;
        cmd_op = 3'd0; cmd_data = 4'b0101; cmd_cnt = 3'd0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("ab_mode", {6'd0, usr_mode}, 8'd1);
            chk("ab_busy_ready", {7'd0, cmd_ready}, 8'd0);
            if (c == 3) abort = 1'b1;
        end
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("ab_mode_after", {6'd0, usr_mode}, 8'd0);
        chk("ab_no_done", {7'd0, done}, 8'd0);
        chk("ab_ready_after", {7'd0, cmd_ready}, 8'd1);
        chk("ab_q", {4'd0, sr}, {4'd0, ref_result(3'd1, 4'b1111, 4'd0, 3, 1'b0)});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("ab_next_load", {6'd0, usr_mode}, 8'd3);
        chk("ab_next_par", {4'd0, usr_par_in}, 8'b0101);
        @(negedge clk);
        chk("ab_next_done", {7'd0, done}, 8'd1);
        chk("ab_next_res", {4'd0, res}, 8'b0101);
        $display("[TB] abort SHR7 at step 3, queued LOAD 0101 accepted after");

        // Reset during SHIFT of ROR 5.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_cnt = 3'd5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rr_mode1", {6'd0, usr_mode}, 8'd1);
        @(negedge clk);
        chk("rr_mode2", {6'd0, usr_mode}, 8'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rr_mode", {6'd0, usr_mode}, 8'd0);
        chk("rr_par", {4'd0, usr_par_in}, 8'd0);
        chk("rr_si", {7'd0, usr_si}, 8'd0);
        chk("rr_busy", {7'd0, busy}, 8'd0);
        chk("rr_res", {4'd0, res}, 8'd0);
        chk("rr_ready", {7'd0, cmd_ready}, 8'd1);
        for (int c = 0; c < 6; c++) begin
            chk("rr_no_done", {7'd0, done}, 8'd0);
            @(negedge clk);
        end
        $display("[TB] reset during ROR5 dropped the command");

        for (int i = 0; i < 30; i++) begin
            do_cmd(3'($urandom_range(0, 7)), 4'($urandom), 3'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
